// File: rtl/spu_pkg.sv
// Shared definitions for the shift/rotate unit: op codes, element sizes and count masks.
package spu_pkg;

    // Op code layout: bit 2 selects word elements, bit 1 selects rotate, bit 0 selects the immediate count
    typedef enum logic [2:0] {
        OP_SHLH  = 3'd0,
        OP_SHLHI = 3'd1,
        OP_ROTH  = 3'd2,
        OP_ROTHI = 3'd3,
        OP_SHL   = 3'd4,
        OP_SHLI  = 3'd5,
        OP_ROT   = 3'd6,
        OP_ROTI  = 3'd7
    } spu_op_e;

    typedef enum logic {
        ELEM_HALF = 1'b0,
        ELEM_WORD = 1'b1
    } spu_elem_e;

    localparam int HALF_W     = 16;
    localparam int WORD_W     = 32;
    localparam int HALF_CNT_W = 5;
    localparam int WORD_CNT_W = 6;

    localparam logic [6:0] HALF_CNT_MASK = 7'h1F;
    localparam logic [6:0] WORD_CNT_MASK = 7'h3F;

    function automatic spu_elem_e op_elem_size(input spu_op_e op);
        return spu_elem_e'(op[2]);
    endfunction

    function automatic logic op_is_rotate(input spu_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_imm(input spu_op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/spu_elem_shifter.sv
// Combinational left-shift / left-rotate of one ELEM_W-bit element.
// The count carries one bit more than a rotate needs so that a shift
// of ELEM_W or more can be recognised and flushed to zero.
module spu_elem_shifter #(
    parameter int  ELEM_W = 16,
    localparam int CNT_W  = $clog2(ELEM_W) + 1
) (
    input  logic [ELEM_W-1:0] data,
    input  logic [CNT_W-1:0]  count,
    input  logic              rotate,
    output logic [ELEM_W-1:0] result
);

    localparam int ROT_W = CNT_W - 1;

    logic [ROT_W-1:0]    w_rot_amt;
    logic [2*ELEM_W-1:0] w_dbl;

    assign w_rot_amt = count[ROT_W-1:0];

    // Rotate takes the upper half of the doubled word; shift flushes to zero once the count reaches the element width
    always_comb begin
        w_dbl = {data, data} << w_rot_amt;
        if (rotate) begin
            result = w_dbl[2*ELEM_W-1 -: ELEM_W];
        end else if (count[CNT_W-1]) begin
            result = '0;
        end else begin
            result = data << count;
        end
    end

endmodule

// File: rtl/shift_rotate_unit.sv
// SIMD shift/rotate unit: per-halfword or per-word left shift and rotate,
// computed in stage 1 and carried through an elastic valid/data pipeline.
module shift_rotate_unit
    import spu_pkg::*;
#(
    parameter int DATA_W      = 128,
    parameter int PIPE_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] register_RA,
    input  logic [DATA_W-1:0] register_RB,
    input  logic [6:0]        imm7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] register_RT
);

    if (PIPE_STAGES < 1 || PIPE_STAGES > 4 || DATA_W < 32 || (DATA_W % 32) != 0) begin : g_bad_params
        $error("shift_rotate_unit: DATA_W must be a multiple of 32 and PIPE_STAGES must be 1..4");
    end

    localparam int N_HALF = DATA_W / HALF_W;
    localparam int N_WORD = DATA_W / WORD_W;

    spu_op_e                w_op;
    spu_elem_e              w_size;
    logic                   w_rotate;
    logic                   w_imm;
    logic [HALF_CNT_W-1:0]  w_half_imm;
    logic [WORD_CNT_W-1:0]  w_word_imm;
    logic [DATA_W-1:0]      w_half_res;
    logic [DATA_W-1:0]      w_word_res;
    logic [DATA_W-1:0]      w_result;
    logic [PIPE_STAGES-1:0] w_ready;
    logic                   w_unused;

    logic [PIPE_STAGES-1:0] r_valid;
    logic [DATA_W-1:0]      r_data [PIPE_STAGES];

    assign w_op       = spu_op_e'(op);
    assign w_size     = op_elem_size(w_op);
    assign w_rotate   = op_is_rotate(w_op);
    assign w_imm      = op_is_imm(w_op);
    assign w_half_imm = HALF_CNT_W'(imm7 & HALF_CNT_MASK);
    assign w_word_imm = WORD_CNT_W'(imm7 & WORD_CNT_MASK);

    // Only the low count bits of each element matter; the rest of RB and imm7 is intentionally dropped
    assign w_unused = ^{imm7, register_RB};

    for (genvar k = 0; k < N_HALF; k++) begin : g_half
        logic [HALF_CNT_W-1:0] w_cnt;
        assign w_cnt = w_imm ? w_half_imm : register_RB[HALF_W*k +: HALF_CNT_W];
        spu_elem_shifter #(.ELEM_W(HALF_W)) u_shift (
            .data   (register_RA[HALF_W*k +: HALF_W]),
            .count  (w_cnt),
            .rotate (w_rotate),
            .result (w_half_res[HALF_W*k +: HALF_W])
        );
    end

    for (genvar k = 0; k < N_WORD; k++) begin : g_word
        logic [WORD_CNT_W-1:0] w_cnt;
        assign w_cnt = w_imm ? w_word_imm : register_RB[WORD_W*k +: WORD_CNT_W];
        spu_elem_shifter #(.ELEM_W(WORD_W)) u_shift (
            .data   (register_RA[WORD_W*k +: WORD_W]),
            .count  (w_cnt),
            .rotate (w_rotate),
            .result (w_word_res[WORD_W*k +: WORD_W])
        );
    end

    assign w_result = (w_size == ELEM_WORD) ? w_word_res : w_half_res;

    // A stage may load when it or any stage downstream of it has a free slot, or the output is draining
    always_comb begin
        w_ready = '0;
        for (int s = 0; s < PIPE_STAGES; s++) begin
            w_ready[s] = out_ready;
            for (int t = s; t < PIPE_STAGES; t++) begin
                if (!r_valid[t]) begin
                    w_ready[s] = 1'b1;
                end
            end
        end
    end

    // Stage 0 captures the shifted result; later stages copy forward whenever they are allowed to advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_data[s] <= '0;
            end
        end else begin
            if (w_ready[0]) begin
                r_valid[0] <= in_valid;
                if (in_valid) begin
                    r_data[0] <= w_result;
                end
            end
            for (int s = 1; s < PIPE_STAGES; s++) begin
                if (w_ready[s]) begin
                    r_valid[s] <= r_valid[s-1];
                    if (r_valid[s-1]) begin
                        r_data[s] <= r_data[s-1];
                    end
                end
            end
        end
    end

    assign in_ready    = w_ready[0] & ~reset;
    assign out_valid   = r_valid[PIPE_STAGES-1];
    assign register_RT = r_data[PIPE_STAGES-1];

endmodule

// File: doc/shift_rotate_unit.md
SHIFT_ROTATE_UNIT -- requirements
Module: shift_rotate_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning operand and result width in bits (multiple of 32).
REQ-002 SHALL have parameter PIPE_STAGES, default 2, meaning number of register stages from input to output (legal 1..4).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation presented.
REQ-006 SHALL have port in_ready  output  1  unit accepts an operation this cycle.
REQ-007 SHALL have port op  input  3  operation code: SHLH, SHLHI, ROTH, ROTHI, SHL, SHLI, ROT, ROTI.
REQ-008 SHALL have port register_RA  input  DATA_W  source operand.
REQ-009 SHALL have port register_RB  input  DATA_W  per-element shift counts; ignored for immediate ops.
REQ-010 SHALL have port imm7  input  7  immediate shift count for *I ops, broadcast to all elements.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port register_RT  output  DATA_W  result.

Function
REQ-014 Transfers SHALL occur only on cycles with valid and ready both high, on both input and output sides.
REQ-015 Halfword ops (SHLH/SHLHI/ROTH/ROTHI) SHALL treat each 16-bit slice [16k+:16] independently; word ops treat each 32-bit slice independently.
REQ-016 Halfword count SHALL be the low 5 bits of the element's own count field (RB slice or imm7); word count SHALL be the low 6 bits.
REQ-017 Left shift SHALL fill vacated bits with 0; count >= element width SHALL yield 0 for that element; all bits of every element, including the MSB, SHALL be computed.
REQ-018 Rotate SHALL use the count modulo element width (halfword: low 4 bits; word: low 5 bits); bits shifted out of the MSB re-enter at the LSB.
REQ-019 Latency SHALL be exactly PIPE_STAGES cycles from an accepted input to out_valid when out_ready is held high; throughput one operation per cycle.
REQ-020 in_ready SHALL be high when the final stage is empty or is being drained (out_ready high), so each stage advances only when the downstream stage frees.
REQ-021 When out_ready is low and the pipeline is full, every stage SHALL hold its contents and in_ready SHALL be low; no operation is lost or duplicated.
REQ-022 Stages in a non-full pipeline SHALL compress bubbles: a stage advances whenever the next stage is empty, regardless of out_ready.
REQ-023 register_RT SHALL hold stable while out_valid is high and out_ready is low.
REQ-024 An illegal PIPE_STAGES or a DATA_W that is not a multiple of 32 SHALL fail elaboration.

Reset
REQ-025 Asserting reset SHALL immediately clear all stage valid bits, forcing out_valid to 0 and register_RT to 0, including mid-operation; in-flight operations are discarded.
REQ-026 in_ready SHALL be 0 while reset is asserted and 1 in the first cycle after deassertion.

Structure
REQ-027 The op enumeration, element-size encoding, and count-mask constants SHALL live in shared package spu_pkg.
REQ-028 Per-element shifting SHALL be a combinational sub-module spu_elem_shifter (parameter ELEM_W, inputs data/count/rotate), instantiated DATA_W/16 times for halfword and DATA_W/32 times for word, with the op-selected set chosen by a mux.
REQ-029 The shift compute SHALL be placed in stage 1; remaining stages SHALL be pure valid/data registers.

Verification
REQ-030 SHLH, RA halfwords all 16'h8001, RB halfwords 0,1,15,16,31,5,3,2 -> RT halfwords 8001,0002,8000,0000,0000,0020,0008,0004.
REQ-031 ROTHI, RA halfwords 16'h8001, imm7=1 -> every halfword 16'h0003; imm7=17 -> also 16'h0003.
REQ-032 SHL word, RA words 32'h0000_0001, RB words 31,32,63,4 -> RT words 8000_0000, 0, 0, 0000_0010.
REQ-033 Back-to-back 8 ops with out_ready low from cycle 3 for 5 cycles -> in_ready drops once PIPE_STAGES entries are held, all 8 results emerge in order with no loss or duplication.
REQ-034 Reset asserted with pipeline full -> out_valid and RT are 0 in the same cycle; first post-reset op returns after PIPE_STAGES cycles.
